// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button front end: sync, debounce, press/release strobes, hold-to-repeat
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int HOLD_CYCLES     = 24000000,
  parameter int REPEAT_CYCLES   = 8000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic               CLOCK,
  input  logic               RESETn,
  input  logic [NUM_BTN-1:0] PB,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESSED,
    ST_REPEATING
  } state_t;

  // Raw pins idle high, so the synchroniser resets to the released level.
  logic [NUM_BTN-1:0] sync1, sync2;

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= PB;
      sync2 <= sync1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_ch
      logic          s;
      logic          db_q;
      logic [DW-1:0] db_cnt;
      logic [HW-1:0] hold_cnt;
      state_t        state;
      logic          level_q, press_q, release_q, repeat_q;

      assign s = ~sync2[i];

      always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
          db_q   <= 1'b0;
          db_cnt <= '0;
        end else if (s == db_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_q   <= ~db_q;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end

      // Release is tested first so it wins over a coincident repeat boundary.
      always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
          state     <= ST_RELEASED;
          hold_cnt  <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          repeat_q  <= 1'b0;
        end else begin
          press_q   <= 1'b0;
          release_q <= 1'b0;
          repeat_q  <= 1'b0;
          case (state)
            ST_RELEASED: begin
              hold_cnt <= '0;
              if (db_q) begin
                state   <= ST_PRESSED;
                level_q <= 1'b1;
                press_q <= 1'b1;
              end
            end
            ST_PRESSED: begin
              if (!db_q) begin
                state     <= ST_RELEASED;
                level_q   <= 1'b0;
                release_q <= 1'b1;
                hold_cnt  <= '0;
              end else if (REPEAT_EN != 0) begin
                if (hold_cnt == HOLD_LAST) begin
                  state    <= ST_REPEATING;
                  repeat_q <= 1'b1;
                  hold_cnt <= '0;
                end else begin
                  hold_cnt <= hold_cnt + 1'b1;
                end
              end
            end
            ST_REPEATING: begin
              if (!db_q) begin
                state     <= ST_RELEASED;
                level_q   <= 1'b0;
                release_q <= 1'b1;
                hold_cnt  <= '0;
              end else if (hold_cnt == REP_LAST) begin
                repeat_q <= 1'b1;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            default: begin
              state    <= ST_RELEASED;
              level_q  <= 1'b0;
              hold_cnt <= '0;
            end
          endcase
        end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;
      assign btn_repeat[i]  = repeat_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  localparam int NB  = 4;
  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int REP = 8;
  localparam int LAT = DB + 3;

  logic          CLOCK;
  logic          RESETn;
  logic [NB-1:0] pb;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(1)
  ) dut (
    .CLOCK(CLOCK), .RESETn(RESETn), .PB(pb),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  logic [NB-1:0] lvl_exp = '0;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  always @(posedge CLOCK) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input int kind, input int ch);
    ev_t e;
    e.cyc = c; e.kind = kind; e.ch = ch;
    sbq.push_back(e);
  endtask

  // Expected strobes for a press held from negedge cl until negedge ch_up.
  task automatic schedule(input int ch, input int cl, input int ch_up);
    int p, r;
    p = cl + LAT;
    r = ch_up + LAT;
    push(p, 0, ch);
    for (int t = p + HLD; t < r; t += REP) push(t, 2, ch);
    push(r, 1, ch);
  endtask

  task automatic hold_btn(input int ch, input int n);
    pb[ch] = 1'b0;
    schedule(ch, cyc, cyc + n);
    repeat (n) @(negedge CLOCK);
    pb[ch] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  logic [NB-1:0] ep, er, et;
  always @(negedge CLOCK) begin
    ep = '0; er = '0; et = '0;
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].cyc == cyc) begin
        case (sbq[k].kind)
          0: ep[sbq[k].ch] = 1'b1;
          1: er[sbq[k].ch] = 1'b1;
          default: et[sbq[k].ch] = 1'b1;
        endcase
        sbq.delete(k);
      end
    end
    if (ep != 0 || btn_press != 0)   check("press", 32'(btn_press), 32'(ep));
    if (er != 0 || btn_release != 0) check("release", 32'(btn_release), 32'(er));
    if (et != 0 || btn_repeat != 0)  check("repeat", 32'(btn_repeat), 32'(et));
    if ((ep | er) != 0 || (btn_press | btn_release) != 0) begin
      lvl_exp = (lvl_exp | ep) & ~er;
      check("level", 32'(btn_level), 32'(lvl_exp));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int d;
  initial begin
    RESETn = 1'b0;
    pb = '1;
    idle(3);
    #1;
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_press", 32'(btn_press), 32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    check("rst_repeat", 32'(btn_repeat), 32'h0);
    @(negedge CLOCK);
    RESETn = 1'b1;
    idle(6);

    // clean press on channel 0, released before the hold time
    hold_btn(0, 10);
    idle(15);

    // bounce on channel 1, then a steady press
    for (int k = 0; k < 5; k++) begin
      pb[1] = 1'b0; idle(2);
      pb[1] = 1'b1; idle(2);
    end
    hold_btn(1, 12);
    idle(15);

    // long hold with auto-repeat on channel 2
    hold_btn(2, 80);
    idle(15);

    // release acceptance landing on a repeat boundary
    hold_btn(2, HLD + 2 * REP);
    idle(15);

    // asynchronous reset while repeating, button still held
    pb[2] = 1'b0;
    push(cyc + LAT, 0, 2);
    push(cyc + LAT + HLD, 2, 2);
    idle(HLD + LAT + 3);
    #2;
    sbq.delete();
    RESETn = 1'b0;
    lvl_exp = '0;
    #1;
    check("async_rst_level", 32'(btn_level), 32'h0);
    check("async_rst_strobes", 32'(btn_press | btn_release | btn_repeat), 32'h0);
    idle(3);
    RESETn = 1'b1;
    d = cyc;
    schedule(2, d, d + 30);
    idle(30);
    pb[2] = 1'b1;
    idle(15);

    // two channels pressed together, channel 0 too short to be accepted
    pb[0] = 1'b0;
    pb[3] = 1'b0;
    schedule(3, cyc, cyc + 12);
    idle(3);
    pb[0] = 1'b1;
    idle(9);
    pb[3] = 1'b1;
    idle(20);

    check("sb_drained", 32'(sbq.size()), 32'h0);
    check("final_level", 32'(btn_level), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
